pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage.
- Produces the fetch address and a fetch-valid strobe for instruction memory.
- Arbitrates two redirect sources: trap (highest priority) and branch/jump resolved in EX.
- Holds a redirect that arrives during a stall so it is applied, not lost, once the stall clears. Tags every fetch with an epoch so downstream stages can discard wrong-path instructions.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_gen_redir_merge.sv | 46 ++++
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and redirect-kind encoding for the fetch pc generator.
// Imported by pc_gen, pc_redir_merge and the pc_gen_if interface users.
package pc_gen_pkg;

   localparam logic RstEnable   = 1'b1;
   localparam logic True        = 1'b1;
   localparam logic False       = 1'b0;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_REDIR = 2'd1,
      KIND_TRAP  = 2'd2
   } redir_kind_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bus: stalls and redirect requests in, fetch address out.
// master = requester side (pipeline control), slave = pc_gen.
interface pc_gen_if #(
   parameter int AW      = 32,
   parameter int EPOCH_W = 2
);
   logic               if_stall;
   logic               mem_stall;
   logic               trap_valid;
   logic [AW-1:0]      trap_addr;
   logic               redir_valid;
   logic [AW-1:0]      redir_addr;
   logic [AW-1:0]      pc;
   logic               pc_valid;
   logic [EPOCH_W-1:0] pc_epoch;
   logic               redir_pending;
   logic               redirected;

   modport master (
      output if_stall, mem_stall,
      output trap_valid, trap_addr,
      output redir_valid, redir_addr,
      input  pc, pc_valid, pc_epoch,
      input  redir_pending, redirected
   );

   modport slave (
      input  if_stall, mem_stall,
      input  trap_valid, trap_addr,
      input  redir_valid, redir_addr,
      output pc, pc_valid, pc_epoch,
      output redir_pending, redirected
   );
endinterface

// File: rtl/pc_gen_redir_merge.sv
// Priority merge of incoming trap/redirect with the held pending entry.
// Ports: i_trap_*, i_redir_*, i_pend_* in; o_valid/o_kind/o_target out.
module pc_redir_merge
   import pc_gen_pkg::*;
#(
   parameter int AW         = 32,
   parameter int ALIGN_BITS = 0
) (
   input  logic          i_trap_valid,
   input  logic [AW-1:0] i_trap_addr,
   input  logic          i_redir_valid,
   input  logic [AW-1:0] i_redir_addr,
   input  redir_kind_t   i_pend_kind,
   input  logic [AW-1:0] i_pend_addr,
   output logic          o_valid,
   output redir_kind_t   o_kind,
   output logic [AW-1:0] o_target
);

   localparam logic [AW-1:0] MASK = {AW{1'b1}} << ALIGN_BITS;

   logic w_pend_trap;
   logic w_take_redir;

   assign w_pend_trap  = (i_pend_kind == KIND_TRAP);
   // a branch never displaces a trap that is already waiting
   assign w_take_redir = i_redir_valid & ~i_trap_valid & ~w_pend_trap;

   always_comb begin
      o_kind   = i_pend_kind;
      o_target = i_pend_addr;
      unique case (1'b1)
         i_trap_valid: begin
            o_kind   = KIND_TRAP;
            o_target = i_trap_addr & MASK;
         end
         w_take_redir: begin
            o_kind   = KIND_REDIR;
            o_target = i_redir_addr & MASK;
         end
         default: ;
      endcase
      o_valid = (o_kind != KIND_NONE);
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/branch redirect and epochs.
// Ports: clk, rst (sync, active-high), bus (pc_gen_if.slave).
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int            AW         = 32,
   parameter int            INC        = 1,
   parameter logic [AW-1:0] RESET_VEC  = '0,
   parameter int            ALIGN_BITS = 0,
   parameter int            EPOCH_W    = 2
) (
   input logic     clk,
   input logic     rst,
   pc_gen_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]         r_state;
   logic [AW-1:0]      r_pc;
   logic               r_pc_valid;
   logic [EPOCH_W-1:0] r_epoch;
   redir_kind_t        r_pend_kind;
   logic [AW-1:0]      r_pend_addr;
   logic               r_redirected;

   logic               w_stalled;
   logic               w_run;
   logic               w_advance;
   logic               w_in_valid;
   logic               w_m_valid;
   redir_kind_t        w_m_kind;
   logic [AW-1:0]      w_m_target;

   assign w_stalled  = bus.if_stall | bus.mem_stall;
   assign w_run      = (r_state == ST_RUN);
   assign w_advance  = w_run & ~w_stalled;
   assign w_in_valid = bus.trap_valid | bus.redir_valid;

   pc_redir_merge #(
      .AW         (AW),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_merge (
      .i_trap_valid  (bus.trap_valid),
      .i_trap_addr   (bus.trap_addr),
      .i_redir_valid (bus.redir_valid),
      .i_redir_addr  (bus.redir_addr),
      .i_pend_kind   (r_pend_kind),
      .i_pend_addr   (r_pend_addr),
      .o_valid       (w_m_valid),
      .o_kind        (w_m_kind),
      .o_target      (w_m_target)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_VEC;
         r_pc_valid   <= ChipDisable;
         r_epoch      <= '0;
         r_pend_kind  <= KIND_NONE;
         r_pend_addr  <= '0;
         r_redirected <= False;
      end else if (!w_run) begin
         // first fetch is RESET_VEC itself; redirects here are dropped
         r_state      <= ST_RUN;
         r_pc_valid   <= ChipEnable;
         r_redirected <= False;
      end else begin
         // epoch moves at capture so in-flight fetches go stale at once
         if (w_in_valid) begin
            r_epoch <= r_epoch + EPOCH_W'(1);
         end
         if (w_advance) begin
            r_pend_kind <= KIND_NONE;
            if (w_m_valid) begin
               r_pc         <= w_m_target;
               r_redirected <= True;
            end else begin
               r_pc         <= r_pc + AW'(INC);
               r_redirected <= False;
            end
         end else begin
            r_pend_kind  <= w_m_kind;
            r_pend_addr  <= w_m_target;
            r_redirected <= False;
         end
      end
   end

   assign bus.pc            = r_pc;
   assign bus.pc_valid      = r_pc_valid;
   assign bus.pc_epoch      = r_epoch;
   assign bus.redir_pending = (r_pend_kind != KIND_NONE);
   assign bus.redirected    = r_redirected;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: two configurations checked against a slot model.
// Directed test-plan steps followed by randomized traffic.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifs = 1'b0;
   logic        mems = 1'b0;
   logic        tv = 1'b0;
   logic [31:0] ta = '0;
   logic        rv = 1'b0;
   logic [31:0] ra = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_gen_if #(.AW(32), .EPOCH_W(2)) if_a ();
   pc_gen_if #(.AW(8),  .EPOCH_W(2)) if_b ();

   assign if_a.if_stall    = ifs;
   assign if_a.mem_stall   = mems;
   assign if_a.trap_valid  = tv;
   assign if_a.trap_addr   = ta;
   assign if_a.redir_valid = rv;
   assign if_a.redir_addr  = ra;
   assign if_b.if_stall    = ifs;
   assign if_b.mem_stall   = mems;
   assign if_b.trap_valid  = tv;
   assign if_b.trap_addr   = ta[7:0];
   assign if_b.redir_valid = rv;
   assign if_b.redir_addr  = ra[7:0];

   pc_gen #(
      .AW(32), .INC(4), .RESET_VEC(32'h1000),
      .ALIGN_BITS(2), .EPOCH_W(2)
   ) u_a (
      .clk(clk), .rst(rst), .bus(if_a.slave)
   );

   pc_gen #(
      .AW(8), .INC(1), .RESET_VEC(8'hF0),
      .ALIGN_BITS(0), .EPOCH_W(2)
   ) u_b (
      .clk(clk), .rst(rst), .bus(if_b.slave)
   );

   // Model: one conceptual "waiting redirect" slot plus pc/epoch.
   typedef struct {
      longint pc;
      int     ep;
      bit     pv;
      bit     pt;
      longint ptg;
      bit     run;
      bit     val;
      bit     rd;
   } mdl_t;

   mdl_t ma;
   mdl_t mb;

   function automatic mdl_t mstep(mdl_t m, int aw, int inc,
                                  longint rvec, int al, int ew);
      longint md;
      longint tgt;
      md = longint'(1) << aw;
      if (rst) begin
         m.pc = rvec; m.ep = 0; m.pv = 0; m.pt = 0;
         m.run = 0; m.val = 0; m.rd = 0;
         return m;
      end
      if (!m.run) begin
         m.run = 1; m.val = 1; m.rd = 0;
         return m;
      end
      tgt = (tv ? longint'(ta) : longint'(ra)) % md;
      tgt = (tgt >> al) << al;
      if (tv || rv) m.ep = (m.ep + 1) % (1 << ew);
      if (tv || (rv && !(m.pv && m.pt))) begin
         m.pv = 1; m.pt = tv; m.ptg = tgt;
      end
      if (!(ifs || mems)) begin
         if (m.pv) begin
            m.pc = m.ptg; m.rd = 1; m.pv = 0; m.pt = 0;
         end else begin
            m.pc = (m.pc + inc) % md; m.rd = 0;
         end
      end else begin
         m.rd = 0;
      end
      return m;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cmp_all();
      chk("a_pc",   64'(if_a.pc),            64'(ma.pc));
      chk("a_val",  64'(if_a.pc_valid),      64'(ma.val));
      chk("a_ep",   64'(if_a.pc_epoch),      64'(ma.ep));
      chk("a_pend", 64'(if_a.redir_pending), 64'(ma.pv));
      chk("a_rdir", 64'(if_a.redirected),    64'(ma.rd));
      chk("b_pc",   64'(if_b.pc),            64'(mb.pc));
      chk("b_val",  64'(if_b.pc_valid),      64'(mb.val));
      chk("b_ep",   64'(if_b.pc_epoch),      64'(mb.ep));
      chk("b_pend", 64'(if_b.redir_pending), 64'(mb.pv));
      chk("b_rdir", 64'(if_b.redirected),    64'(mb.rd));
   endtask

   task automatic step();
      ma = mstep(ma, 32, 4, 64'h1000, 2, 2);
      mb = mstep(mb, 8, 1, 64'hF0, 0, 2);
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};

      // reset held three cycles
      rst = 1'b1;
      repeat (3) step();
      chk("rst_pc",  64'(if_a.pc), 64'h1000);
      chk("rst_val", 64'(if_a.pc_valid), 64'h0);
      rst = 1'b0;
      step();
      chk("first_pc",  64'(if_a.pc), 64'h1000);
      chk("first_val", 64'(if_a.pc_valid), 64'h1);
      step();
      chk("seq_1004", 64'(if_a.pc), 64'h1004);
      step();
      chk("seq_1008", 64'(if_a.pc), 64'h1008);
      chk("seq_ep0",  64'(if_a.pc_epoch), 64'h0);

      // redirect while running, target aligned down
      rv = 1'b1; ra = 32'h2003;
      step();
      chk("redir_pc",  64'(if_a.pc), 64'h2000);
      chk("redir_pls", 64'(if_a.redirected), 64'h1);
      chk("redir_ep",  64'(if_a.pc_epoch), 64'h1);
      rv = 1'b0;
      step();
      chk("redir_pls0", 64'(if_a.redirected), 64'h0);
      chk("redir_seq",  64'(if_a.pc), 64'h2004);

      // redirect captured during a 4-cycle memory stall
      mems = 1'b1;
      step();
      rv = 1'b1; ra = 32'h3000;
      step();
      chk("stall_hold", 64'(if_a.pc), 64'h2004);
      chk("stall_pend", 64'(if_a.redir_pending), 64'h1);
      chk("stall_ep",   64'(if_a.pc_epoch), 64'h2);
      rv = 1'b0;
      step();
      step();
      mems = 1'b0;
      step();
      chk("rel_pc",   64'(if_a.pc), 64'h3000);
      chk("rel_pend", 64'(if_a.redir_pending), 64'h0);

      // pending trap not displaced by a later branch
      ifs = 1'b1;
      tv = 1'b1; ta = 32'h80;
      step();
      tv = 1'b0;
      rv = 1'b1; ra = 32'h4000;
      step();
      rv = 1'b0;
      ifs = 1'b0;
      step();
      chk("prio_pc", 64'(if_a.pc), 64'h80);
      chk("prio_ep", 64'(if_a.pc_epoch), 64'h0);

      // simultaneous trap and branch
      tv = 1'b1; ta = 32'h100;
      rv = 1'b1; ra = 32'h200;
      step();
      chk("sim_pc", 64'(if_a.pc), 64'h100);
      chk("sim_ep", 64'(if_a.pc_epoch), 64'h1);
      tv = 1'b0; rv = 1'b0;

      // wrap on the 8-bit instance
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("b_first", 64'(if_b.pc), 64'hF0);
      repeat (15) step();
      chk("b_ff", 64'(if_b.pc), 64'hFF);
      step();
      chk("b_wrap", 64'(if_b.pc), 64'h00);

      // reset while a redirect is pending
      ifs = 1'b1;
      rv = 1'b1; ra = 32'h55;
      step();
      rv = 1'b0;
      chk("b_pend", 64'(if_b.redir_pending), 64'h1);
      rst = 1'b1;
      tv = 1'b1; ta = 32'h77;
      step();
      chk("b_rst_pend", 64'(if_b.redir_pending), 64'h0);
      chk("b_rst_pc",   64'(if_b.pc), 64'hF0);
      tv = 1'b0;
      rst = 1'b0;
      ifs = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 59) == 0);
         ifs  = ($urandom_range(0, 3) == 0);
         mems = ($urandom_range(0, 5) == 0);
         tv   = ($urandom_range(0, 9) == 0);
         rv   = ($urandom_range(0, 4) == 0);
         ta   = $urandom;
         ra   = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
